// File: rtl/packet_slot_allocator_if.sv
// Allocate/release handshake between a slot requester and packet_slot_allocator.
interface packet_slot_allocator_if #(
    parameter int unsigned NUM_ENTRIES = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    logic             alloc_req;
    logic             alloc_gnt;
    logic [IDX_W-1:0] alloc_index;
    logic             release_valid;
    logic [IDX_W-1:0] release_index;

    modport master (
        output alloc_req,
        output release_valid,
        output release_index,
        input  alloc_gnt,
        input  alloc_index
    );

    modport slave (
        input  alloc_req,
        input  release_valid,
        input  release_index,
        output alloc_gnt,
        output alloc_index
    );
endinterface

// File: rtl/packet_slot_allocator.sv
// Free-slot bitmap owner: post-reset clear sweep, highest-index-first allocation,
// release handling with occupancy count and sticky error flags.
module next_free_index_comb #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] free_map,
    output logic [IDX_W-1:0]       next_free_index,
    output logic                   next_free_index_valid
);
    // Ascending scan, so the highest free index is the last one written.
    always_comb begin
        next_free_index       = '0;
        next_free_index_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (free_map[i]) begin
                next_free_index       = IDX_W'(i);
                next_free_index_valid = 1'b1;
            end
        end
    end
endmodule

module packet_slot_allocator #(
    parameter int unsigned NUM_ENTRIES = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    packet_slot_allocator_if.slave             bus,
    output logic                               clear_en,
    output logic [$clog2(NUM_ENTRIES)-1:0]     clear_index,
    output logic                               init_busy,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   used_count,
    output logic                               full,
    output logic                               empty,
    input  logic                               err_clear,
    output logic                               err_double_free,
    output logic                               err_bad_index
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                 state, next_state;
    logic [IDX_W-1:0]       sweep_cnt;
    logic [NUM_ENTRIES-1:0] bitmap;
    logic [IDX_W-1:0]       nf_index;
    logic                   nf_valid;
    logic                   sweep_last;
    logic                   alloc_fire;
    logic                   rel_bad;
    logic                   rel_double;
    logic                   rel_ok;

    next_free_index_comb #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_next_free (
        .free_map              (bitmap),
        .next_free_index       (nf_index),
        .next_free_index_valid (nf_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        clear_en      = 1'b0;
        init_busy     = 1'b0;
        bus.alloc_gnt = 1'b0;
        case (state)
            INIT: begin
                clear_en  = 1'b1;
                init_busy = 1'b1;
                if (sweep_last) next_state = READY;
            end
            READY: bus.alloc_gnt = nf_valid;
            default: next_state = INIT;
        endcase
    end

    assign bus.alloc_index = nf_index;
    assign clear_index     = sweep_cnt;
    assign sweep_last      = (sweep_cnt == IDX_W'(NUM_ENTRIES - 1));

    // Out-of-range is checked first so the bitmap is never indexed past its end.
    always_comb begin
        alloc_fire = bus.alloc_req && bus.alloc_gnt;
        rel_bad    = 1'b0;
        rel_double = 1'b0;
        rel_ok     = 1'b0;
        if (state == READY && bus.release_valid) begin
            if ({1'b0, bus.release_index} >= (IDX_W + 1)'(NUM_ENTRIES)) rel_bad = 1'b1;
            else if (bitmap[bus.release_index])                         rel_double = 1'b1;
            else                                                        rel_ok = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_cnt       <= '0;
            bitmap          <= '0;
            used_count      <= '0;
            err_double_free <= 1'b0;
            err_bad_index   <= 1'b0;
        end else begin
            if (state == INIT) begin
                bitmap[sweep_cnt] <= 1'b1;
                sweep_cnt         <= sweep_last ? '0 : sweep_cnt + 1'b1;
            end else begin
                if (alloc_fire) bitmap[bus.alloc_index]   <= 1'b0;
                if (rel_ok)     bitmap[bus.release_index] <= 1'b1;
                if (alloc_fire && !rel_ok)      used_count <= used_count + 1'b1;
                else if (rel_ok && !alloc_fire) used_count <= used_count - 1'b1;
            end
            // A new error in the same cycle overrides err_clear.
            if (err_clear)  err_double_free <= 1'b0;
            if (rel_double) err_double_free <= 1'b1;
            if (err_clear)  err_bad_index   <= 1'b0;
            if (rel_bad)    err_bad_index   <= 1'b1;
        end
    end

    assign full  = (used_count == CNT_W'(NUM_ENTRIES));
    assign empty = (used_count == '0);
endmodule

// File: tb/tb_packet_slot_allocator.sv
// Directed self-checking bench for packet_slot_allocator with NUM_ENTRIES=8.
module tb_packet_slot_allocator;
    localparam int unsigned N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_en;
    logic [2:0] clear_index;
    logic       init_busy;
    logic [3:0] used_count;
    logic       full;
    logic       empty;
    logic       err_clear;
    logic       err_double_free;
    logic       err_bad_index;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    packet_slot_allocator_if #(.NUM_ENTRIES(N)) bus ();

    packet_slot_allocator #(.NUM_ENTRIES(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .clear_en        (clear_en),
        .clear_index     (clear_index),
        .init_busy       (init_busy),
        .used_count      (used_count),
        .full            (full),
        .empty           (empty),
        .err_clear       (err_clear),
        .err_double_free (err_double_free),
        .err_bad_index   (err_bad_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_slot(input logic [2:0] idx);
        bus.release_valid = 1'b1;
        bus.release_index = idx;
        tick();
        bus.release_valid = 1'b0;
    endtask

    task automatic alloc_one(input int unsigned exp_idx);
        bus.alloc_req = 1'b1;
        #1;
        check("alloc_gnt", 32'(bus.alloc_gnt), 1);
        check("alloc_index", 32'(bus.alloc_index), exp_idx);
        tick();
        bus.alloc_req = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < int'(N); i++) begin
            #1;
            check({tag, "_busy"}, 32'(init_busy), 1);
            check({tag, "_clear_en"}, 32'(clear_en), 1);
            check({tag, "_clear_index"}, 32'(clear_index), 32'(i));
            check({tag, "_gnt"}, 32'(bus.alloc_gnt), 0);
            tick();
        end
        #1;
        check({tag, "_done_busy"}, 32'(init_busy), 0);
        check({tag, "_done_clear_en"}, 32'(clear_en), 0);
        check({tag, "_first_gnt"}, 32'(bus.alloc_gnt), 1);
        check({tag, "_first_index"}, 32'(bus.alloc_index), 7);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_used"}, 32'(used_count), 0);
    endtask

    initial begin
        rst               = 1'b1;
        err_clear         = 1'b0;
        bus.alloc_req     = 1'b0;
        bus.release_valid = 1'b0;
        bus.release_index = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state, first cycle of the sweep
        check("rst_busy", 32'(init_busy), 1);
        check("rst_clear_en", 32'(clear_en), 1);
        check("rst_clear_index", 32'(clear_index), 0);
        check("rst_gnt", 32'(bus.alloc_gnt), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_errs", 32'({err_double_free, err_bad_index}), 0);

        // Requests and releases during INIT must be ignored
        fork
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                bus.alloc_req     = 1'b1;
                bus.release_valid = 1'b1;
                bus.release_index = 3'd2;
                @(posedge clk); #1;
                bus.alloc_req     = 1'b0;
                bus.release_valid = 1'b0;
            end
        join_none
        sweep("init");
        check("init_ignore_err", 32'(err_double_free), 0);

        // Fill: highest free index first
        for (int i = 0; i < int'(N); i++) alloc_one(32'(7 - i));
        check("fill_full", 32'(full), 1);
        check("fill_used", 32'(used_count), 8);
        check("fill_empty", 32'(empty), 0);
        bus.alloc_req = 1'b1;
        #1;
        check("full_gnt", 32'(bus.alloc_gnt), 0);
        tick();
        bus.alloc_req = 1'b0;
        check("full_used_hold", 32'(used_count), 8);

        // Release and reuse
        release_slot(3'd3);
        check("rel3_used", 32'(used_count), 7);
        check("rel3_full", 32'(full), 0);
        check("rel3_gnt", 32'(bus.alloc_gnt), 1);
        check("rel3_index", 32'(bus.alloc_index), 3);
        check("rel3_err", 32'(err_double_free), 0);

        // Simultaneous alloc and release: free {1,0}, slot 5 in use
        alloc_one(3);
        release_slot(3'd1);
        release_slot(3'd0);
        check("pre_sim_used", 32'(used_count), 6);
        bus.alloc_req     = 1'b1;
        bus.release_valid = 1'b1;
        bus.release_index = 3'd5;
        #1;
        check("sim_gnt", 32'(bus.alloc_gnt), 1);
        check("sim_index", 32'(bus.alloc_index), 1);
        tick();
        bus.alloc_req     = 1'b0;
        bus.release_valid = 1'b0;
        check("sim_used", 32'(used_count), 6);
        alloc_one(5);
        check("post_sim_used", 32'(used_count), 7);

        // Double free of a free slot, then err_clear
        release_slot(3'd2);
        check("rel2_used", 32'(used_count), 6);
        release_slot(3'd2);
        check("dfree_flag", 32'(err_double_free), 1);
        check("dfree_used", 32'(used_count), 6);
        check("dfree_index", 32'(bus.alloc_index), 2);
        check("dfree_bad_idx", 32'(err_bad_index), 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("errclr_flag", 32'(err_double_free), 0);

        // New error in the same cycle as err_clear wins
        err_clear = 1'b1;
        release_slot(3'd0);
        err_clear = 1'b0;
        check("errclr_race", 32'(err_double_free), 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("errclr_again", 32'(err_double_free), 0);

        // Reset mid-operation with 5 slots allocated
        release_slot(3'd7);
        check("pre_rst_used", 32'(used_count), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_used", 32'(used_count), 0);
        sweep("reinit");

        // Release while empty is a double free
        release_slot(3'd4);
        check("empty_dfree", 32'(err_double_free), 1);
        check("empty_used", 32'(used_count), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/packet_slot_allocator.md
Name: packet_slot_allocator

Overview:
- Sequential owner of the packet-buffer free-slot bitmap in the packet controller.
- Runs a post-reset clear sweep over all slots, then serves single-cycle allocate requests and accepts releases.
- Instantiates next_free_index_comb to pick the slot; the rule is the highest-index free slot.
- Tracks occupancy, and flags double-free and out-of-range release errors.

Parameters:
- NUM_ENTRIES, 8, number of buffer slots (≥2).
- IDX_W, $clog2(NUM_ENTRIES), slot index width (derived, not overridden).
- CNT_W, $clog2(NUM_ENTRIES+1), occupancy counter width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  1  requester wants a slot this cycle.
- alloc_gnt  out  1  slot available; allocation fires when alloc_req && alloc_gnt.
- alloc_index  out  IDX_W  granted slot index; valid while alloc_gnt=1.
- release_valid  in  1  return a slot this cycle.
- release_index  in  IDX_W  slot being returned.
- clear_en  out  1  init sweep strobe to clear the slot's buffer metadata.
- clear_index  out  IDX_W  slot being cleared.
- init_busy  out  1  high during the init sweep.
- used_count  out  CNT_W  number of allocated slots.
- full  out  1  used_count==NUM_ENTRIES.
- empty  out  1  used_count==0.
- err_clear  in  1  clears sticky error flags.
- err_double_free  out  1  sticky; set when a free slot is released.
- err_bad_index  out  1  sticky; set when release_index>=NUM_ENTRIES.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on posedge clk.
- Reset values: state=INIT, sweep counter=0, bitmap=all 0, used_count=0, err flags=0.
  - Outputs in the first cycle after reset: init_busy=1, clear_en=1, clear_index=0, alloc_gnt=0, empty=1, full=0.
- State INIT:
  - clear_en=1 and clear_index=counter each cycle.
  - On each edge, bitmap[counter] is set to 1 (free) and the counter increments.
  - After clear_index=NUM_ENTRIES-1, go to READY. INIT lasts exactly NUM_ENTRIES cycles.
  - alloc_gnt=0 throughout INIT.
  - release_valid is ignored in INIT: no bitmap change, no error.
- State READY:
  - clear_en=0 and init_busy=0.
  - alloc_gnt=next_free_index_valid and alloc_index=next_free_index. These are combinational from the registered bitmap, so the grant is visible in the same cycle as the request.
  - On an alloc fire, bitmap[alloc_index] is cleared on the next edge.
  - On release_valid with a legal index, bitmap[release_index] is set on the next edge.
- Simultaneous alloc fire and release:
  - The grant is computed from the pre-edge bitmap; the released slot is not grantable until the next cycle.
  - Both bitmap updates apply on the same edge.
  - used_count is unchanged.
  - The allocated index never equals a legally released index, because the allocated slot is free and the released slot is in use.
- Full and empty:
  - When full, alloc_gnt=0 and alloc_req is a no-op.
  - When empty, a release of any in-range index sets err_double_free.
- Error cases: the bitmap and count are unchanged in each.
  - Double free: release of a slot whose bitmap bit is already 1 sets err_double_free.
  - Bad index: release_index>=NUM_ENTRIES sets err_bad_index. This is reachable only when NUM_ENTRIES is not a power of 2.
- used_count update: +1 on alloc-only, −1 on legal release-only, unchanged on both or neither. It never wraps. full and empty are registered-equivalent decodes of used_count.
- err_clear: clears both flags on the next edge. A new error in the same cycle as err_clear wins, and the flag is set.
- Reset mid-operation: state returns to INIT, all slots become unallocated, and the sweep restarts at index 0. Requests are ignored until READY.

Test Plan:
- Init sweep: rst pulse with NUM_ENTRIES=8 → 8 cycles of init_busy=1, clear_en=1, clear_index 0..7. Cycle 9 shows alloc_gnt=1, alloc_index=7, empty=1.
- Fill: 8 back-to-back alloc_req cycles → alloc_index 7,6,5,4,3,2,1,0. After the 8th, full=1 and used_count=8. A 9th request sees alloc_gnt=0 and the count stays 8.
- Release and reuse: from full, release index 3 → next cycle used_count=7, alloc_gnt=1, alloc_index=3.
- Simultaneous: slots 1 and 0 free and 5 allocated. alloc_req plus release_valid(5) in the same cycle → grant index 1, used_count unchanged at 6. The next allocation returns index 5.
- Double free: slot 2 free, release_valid(2) → err_double_free=1, bitmap and count unchanged. err_clear then drops the flag the next cycle.
- Reset mid-operation: 5 slots allocated, assert rst → 8-cycle sweep repeats, used_count=0, and the first grant is index 7.
